// File: rtl/composite_encoder.sv
// Composite video encoder: line-timing FSM, quadrature subcarrier modulator and a
// fixed 3-stage datapath producing saturated composite samples plus a burst flag.
module composite_encoder #(
    parameter int          DATA_WIDTH = 12,
    parameter logic [31:0] PHASE_INC  = 32'd204987064,
    parameter int          SYNC_LEN   = 353,
    parameter int          BREEZE_LEN = 45,
    parameter int          BURST_LEN  = 189,
    parameter int          BP_LEN     = 60,
    parameter int          SYNC_LEVEL = -600,
    parameter int          BURST_AMP  = 160
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] luma_in,
    input  logic signed [DATA_WIDTH-1:0] u_in,
    input  logic signed [DATA_WIDTH-1:0] v_in,
    input  logic                         hsync_in,
    input  logic                         active_in,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         burst_active
);

    localparam int PW = DATA_WIDTH + 10;  // product width
    localparam int SW = PW + 1;           // sum width
    localparam int FW = DATA_WIDTH + 3;   // final add width

    localparam logic [15:0] SyncLast   = 16'(SYNC_LEN - 1);
    localparam logic [15:0] BreezeLast = 16'(BREEZE_LEN - 1);
    localparam logic [15:0] BurstLast  = 16'(BURST_LEN - 1);
    localparam logic [15:0] BpLast     = 16'(BP_LEN - 1);

    localparam logic signed [DATA_WIDTH-1:0] SyncLevel = DATA_WIDTH'(SYNC_LEVEL);
    localparam logic signed [DATA_WIDTH-1:0] BurstNeg  = DATA_WIDTH'(-BURST_AMP);
    localparam logic signed [FW-1:0] MaxV = FW'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [FW-1:0] MinV = FW'(-(2 ** (DATA_WIDTH - 1)));

    typedef enum logic [2:0] {
        StIdle, StSync, StBreeze, StBurst, StBackPorch, StActive
    } state_e;

    // Quarter-wave table mirrored into a 64-entry round(511*sin) wave.
    function automatic logic signed [9:0] sin_lut(input logic [5:0] idx);
        logic [4:0] q;
        logic [8:0] mag;
        q = idx[4] ? (5'd16 - {1'b0, idx[3:0]}) : {1'b0, idx[3:0]};
        case (q)
            5'd0:  mag = 9'd0;
            5'd1:  mag = 9'd50;
            5'd2:  mag = 9'd100;
            5'd3:  mag = 9'd148;
            5'd4:  mag = 9'd196;
            5'd5:  mag = 9'd241;
            5'd6:  mag = 9'd284;
            5'd7:  mag = 9'd324;
            5'd8:  mag = 9'd361;
            5'd9:  mag = 9'd395;
            5'd10: mag = 9'd425;
            5'd11: mag = 9'd451;
            5'd12: mag = 9'd472;
            5'd13: mag = 9'd489;
            5'd14: mag = 9'd501;
            5'd15: mag = 9'd509;
            5'd16: mag = 9'd511;
            default: mag = 9'd0;
        endcase
        sin_lut = idx[5] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    logic [31:0] phase_q, phase_d;
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        hsync_q;
    logic        hsync_rise;

    logic signed [DATA_WIDTH-1:0] luma1_q, luma1_d, u1_q, u1_d, v1_q, v1_d;
    logic signed [9:0]            sin1_q, sin1_d, cos1_q, cos1_d;
    logic                         burst1_q, burst1_d;

    logic signed [SW-1:0]         sum2_q, sum2_d;
    logic signed [DATA_WIDTH-1:0] luma2_q;
    logic                         burst2_q;

    logic signed [DATA_WIDTH-1:0] data_q, data_d;
    logic                         burst3_q;

    logic signed [PW-1:0] prod_u, prod_v;
    logic signed [SW-1:0] shifted;
    logic signed [FW-1:0] total;

    assign hsync_rise = hsync_in & ~hsync_q;
    assign phase_d    = phase_q + PHASE_INC;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        if (hsync_rise) begin
            state_d = StSync;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle, StActive: cnt_d = '0;
                StSync: if (cnt_q == SyncLast) begin
                    state_d = StBreeze;
                    cnt_d   = '0;
                end
                StBreeze: if (cnt_q == BreezeLast) begin
                    state_d = StBurst;
                    cnt_d   = '0;
                end
                StBurst: if (cnt_q == BurstLast) begin
                    state_d = StBackPorch;
                    cnt_d   = '0;
                end
                StBackPorch: if (cnt_q == BpLast) begin
                    state_d = StActive;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Every state is mapped onto the same luma + (u*sin + v*cos) >>> 9 datapath.
    always_comb begin
        luma1_d  = '0;
        u1_d     = '0;
        v1_d     = '0;
        burst1_d = 1'b0;
        sin1_d   = sin_lut(phase_q[31:26]);
        cos1_d   = sin_lut(phase_q[31:26] + 6'd16);
        case (state_q)
            StSync: luma1_d = SyncLevel;
            StBurst: begin
                u1_d     = BurstNeg;
                burst1_d = 1'b1;
            end
            StActive: if (active_in) begin
                luma1_d = luma_in;
                u1_d    = u_in;
                v1_d    = v_in;
            end
            default: ;
        endcase
    end

    always_comb begin
        prod_u  = PW'(u1_q) * PW'(sin1_q);
        prod_v  = PW'(v1_q) * PW'(cos1_q);
        sum2_d  = SW'(prod_u) + SW'(prod_v);
        shifted = sum2_q >>> 9;
        total   = FW'(shifted) + FW'(luma2_q);
        if (total > MaxV) begin
            data_d = MaxV[DATA_WIDTH-1:0];
        end else if (total < MinV) begin
            data_d = MinV[DATA_WIDTH-1:0];
        end else begin
            data_d = total[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= '0;
            state_q  <= StIdle;
            cnt_q    <= '0;
            hsync_q  <= 1'b0;
            luma1_q  <= '0;
            u1_q     <= '0;
            v1_q     <= '0;
            sin1_q   <= '0;
            cos1_q   <= '0;
            burst1_q <= 1'b0;
            sum2_q   <= '0;
            luma2_q  <= '0;
            burst2_q <= 1'b0;
            data_q   <= '0;
            burst3_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hsync_q  <= hsync_in;
            luma1_q  <= luma1_d;
            u1_q     <= u1_d;
            v1_q     <= v1_d;
            sin1_q   <= sin1_d;
            cos1_q   <= cos1_d;
            burst1_q <= burst1_d;
            sum2_q   <= sum2_d;
            luma2_q  <= luma1_q;
            burst2_q <= burst1_q;
            data_q   <= data_d;
            burst3_q <= burst2_q;
        end
    end

    assign data_out     = data_q;
    assign burst_active = burst3_q;

endmodule

// File: tb/tb_composite_encoder.sv
// Bench for composite_encoder: behavioural line model feeds a 3-deep scoreboard,
// plus directed checks on segment lengths, burst amplitude, saturation and reset.
module tb_composite_encoder;

    localparam int          DW        = 12;
    localparam logic [31:0] PHASE_INC = 32'd204987064;
    localparam int          S_LEN     = 353;
    localparam int          BZ_LEN    = 45;
    localparam int          BU_LEN    = 189;
    localparam int          BP_LEN    = 60;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] luma_in, u_in, v_in;
    logic                 hsync_in, active_in;
    logic signed [DW-1:0] data_out;
    logic                 burst_active;

    composite_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .luma_in      (luma_in),
        .u_in         (u_in),
        .v_in         (v_in),
        .hsync_in     (hsync_in),
        .active_in    (active_in),
        .data_out     (data_out),
        .burst_active (burst_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        bit b;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [31:0] phase_m;
    bit          idle_m;
    int          since_m;
    bit          prev_m;

    int tick_idx, sync_cnt, burst_cnt, burst_abs_max, max_out, nonzero_cnt, first_sync_tick;

    function automatic int lut(int k);
        real r;
        r = 511.0 * $sin(2.0 * 3.141592653589793 * k / 64.0);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    function automatic int sat(int x);
        if (x > 2047) return 2047;
        if (x < -2048) return -2048;
        return x;
    endfunction

    task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int k, s, c, l, u, v;
        k = int'(phase_m[31:26]);
        s = lut(k);
        c = lut((k + 16) % 64);
        l = int'(luma_in);
        u = int'(u_in);
        v = int'(v_in);
        e.d = 0;
        e.b = 1'b0;
        if (idle_m) begin
            e.d = 0;
        end else if (since_m < S_LEN) begin
            e.d = -600;
        end else if (since_m < S_LEN + BZ_LEN) begin
            e.d = 0;
        end else if (since_m < S_LEN + BZ_LEN + BU_LEN) begin
            e.d = (-160 * s) >>> 9;
            e.b = 1'b1;
        end else if (since_m < S_LEN + BZ_LEN + BU_LEN + BP_LEN) begin
            e.d = 0;
        end else if (active_in) begin
            e.d = sat(l + ((u * s + v * c) >>> 9));
        end
        return e;
    endfunction

    task automatic model_reset();
        exp_t z;
        z.d = 0;
        z.b = 1'b0;
        phase_m = '0;
        idle_m  = 1'b1;
        since_m = 0;
        prev_m  = 1'b0;
        sb.delete();
        sb.push_back(z);
        sb.push_back(z);
    endtask

    task automatic clr_stats();
        tick_idx = 0;
        sync_cnt = 0;
        burst_cnt = 0;
        burst_abs_max = 0;
        max_out = -100000;
        nonzero_cnt = 0;
        first_sync_tick = 0;
    endtask

    task automatic tick();
        exp_t e, o;
        int   d;
        e = model_out();
        sb.push_back(e);
        if (hsync_in && !prev_m) begin
            idle_m  = 1'b0;
            since_m = 0;
        end else if (!idle_m && since_m < 1000000) begin
            since_m++;
        end
        prev_m  = hsync_in;
        phase_m = phase_m + PHASE_INC;
        @(posedge clk);
        #1;
        tick_idx++;
        o = sb.pop_front();
        check("data_out", data_out, o.d);
        check("burst_active", {31'b0, burst_active}, {31'b0, o.b});
        d = int'(data_out);
        if (d == -600) begin
            sync_cnt++;
            if (first_sync_tick == 0) first_sync_tick = tick_idx;
        end
        if (burst_active) begin
            burst_cnt++;
            if (d > burst_abs_max) burst_abs_max = d;
            if (-d > burst_abs_max) burst_abs_max = -d;
        end
        if (d > max_out) max_out = d;
        if (d != 0) nonzero_cnt++;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1;
        luma_in = '0;
        u_in = '0;
        v_in = '0;
        hsync_in = 1'b0;
        active_in = 1'b0;
        clr_stats();
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", data_out, 0);
        check("reset_burst", {31'b0, burst_active}, 0);
        rst = 1'b0;
        model_reset();

        // Idle with no hsync edge.
        clr_stats();
        run(1000);
        check("idle_nonzero", nonzero_cnt, 0);

        // First full line, flat luma of 500 in the active region.
        luma_in = 12'sd500;
        active_in = 1'b1;
        clr_stats();
        hsync_in = 1'b1;
        tick();
        hsync_in = 1'b0;
        run(700);
        check("sync_len", sync_cnt, S_LEN);
        check("sync_latency", first_sync_tick, 4);
        check("burst_len", burst_cnt, BU_LEN);
        check("burst_amp_ok", (burst_abs_max <= 160) ? 1 : 0, 1);
        check("active_luma", data_out, 500);

        // Positive saturation over more than a subcarrier cycle.
        luma_in = 12'sd2000;
        u_in = 12'sd2047;
        clr_stats();
        run(70);
        check("sat_peak", max_out, 2047);

        // Random pixels with active_in toggling.
        for (int i = 0; i < 300; i++) begin
            luma_in = DW'($urandom);
            u_in = DW'($urandom);
            v_in = DW'($urandom);
            active_in = 1'($urandom);
            tick();
        end
        active_in = 1'b0;
        luma_in = '0;
        u_in = '0;
        v_in = '0;
        run(5);

        // Edge mid-SYNC restarts the sync segment.
        clr_stats();
        hsync_in = 1'b1;
        tick();
        hsync_in = 1'b0;
        run(99);
        hsync_in = 1'b1;
        tick();
        hsync_in = 1'b0;
        run(498);
        check("resync_len", sync_cnt, 100 + S_LEN);
        check("resync_latency", first_sync_tick, 4);

        // Edge 100 cycles into BURST: only the burst samples already in flight emerge.
        clr_stats();
        hsync_in = 1'b1;
        tick();
        hsync_in = 1'b0;
        run(400);
        check("burst_cut", burst_cnt, 3);
        check("cut_sync_latency", first_sync_tick, 4);
        check("cut_sync_len", sync_cnt, S_LEN);
        luma_in = 12'sd500;
        active_in = 1'b1;
        run(300);
        check("active_luma2", data_out, 500);

        // Asynchronous reset in ACTIVE clears the output before the next edge.
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_data", data_out, 0);
        check("async_rst_burst", {31'b0, burst_active}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clr_stats();
        run(50);
        check("post_rst_idle", nonzero_cnt, 0);
        clr_stats();
        hsync_in = 1'b1;
        tick();
        hsync_in = 1'b0;
        run(10);
        check("post_rst_sync", first_sync_tick, 4);

        // hsync held high through reset release counts as an edge.
        rst = 1'b1;
        hsync_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clr_stats();
        run(10);
        hsync_in = 1'b0;
        run(360);
        check("rst_hold_sync_len", sync_cnt, S_LEN);
        check("rst_hold_latency", first_sync_tick, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
